// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core types: ALU opcodes, operand-A select, ID/EX register image
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_BLT  = 4'b1000;
  localparam logic [3:0] ALU_BGE  = 4'b1001;
  localparam logic [3:0] ALU_BLTU = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;
  localparam logic [3:0] ALU_BEQ  = 4'b1100;
  localparam logic [3:0] ALU_BNE  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'b00,
    A_SEL_PC   = 2'b01,
    A_SEL_ZERO = 2'b10,
    A_SEL_RSVD = 2'b11
  } a_sel_e;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic [XLEN-1:0]  pc;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [3:0]       alu_ctrl;
    a_sel_e           a_sel;
    logic             b_imm;
  } id_ex_regs_t;

  // A bubble is an all-zero image: invalid, no side effects, rd=x0, ALU op ADD.
  function automatic id_ex_regs_t id_ex_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational operand forwarding select for one source register
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic hit_exmem;
  logic hit_memwb;

  // x0 is hardwired to zero, so a write aimed at it must never be forwarded.
  assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
  assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

  always_comb begin
    fwd_data = rs_data;
    if (hit_exmem)
      fwd_data = exmem_result;
    else if (hit_memwb)
      fwd_data = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_alu_ctrl,
  input  logic [1:0]  id_a_sel,
  input  logic        id_b_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_reg_write,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_reg_write,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_ctrl,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_branch_target,
  output logic        load_use_stall
);

  id_ex_regs_t q;
  id_ex_regs_t id_fields;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic        hazard;

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.reg_write = id_reg_write;
    id_fields.mem_read  = id_mem_read;
    id_fields.mem_write = id_mem_write;
    id_fields.branch    = id_branch;
    id_fields.jump      = id_jump;
    id_fields.pc        = id_pc;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rd        = id_rd;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
    id_fields.alu_ctrl  = id_alu_ctrl;
    id_fields.a_sel     = a_sel_e'(id_a_sel);
    id_fields.b_imm     = id_b_imm;
  end

  // A load in EX cannot forward in time to a dependent ID instruction.
  assign hazard = q.valid && q.mem_read && (q.rd != '0) && id_valid &&
                  ((id_rs1 == q.rd) || (id_rs2 == q.rd));
  assign load_use_stall = hazard && !stall && !flush;

  fwd_unit u_fwd_rs1 (
    .rs              (q.rs1),
    .rs_data         (q.rs1_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs              (q.rs2),
    .rs_data         (q.rs2_data),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2)
  );

  // While held, operand data keeps absorbing forwarded results so a value
  // retiring from MEM/WB during the stall is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= id_ex_bubble();
    end else if (stall) begin
      q.rs1_data <= fwd_rs1;
      q.rs2_data <= fwd_rs2;
    end else if (load_use_stall) begin
      q <= id_ex_bubble();
    end else begin
      q <= id_fields;
    end
  end

  always_comb begin
    ex_alu_a = fwd_rs1;
    case (q.a_sel)
      A_SEL_PC:   ex_alu_a = q.pc;
      A_SEL_ZERO: ex_alu_a = '0;
      default:    ex_alu_a = fwd_rs1;
    endcase
  end

  assign ex_alu_b         = q.b_imm ? q.imm : fwd_rs2;
  assign ex_store_data    = fwd_rs2;
  assign ex_branch_target = q.pc + q.imm;

  assign ex_valid     = q.valid;
  assign ex_reg_write = q.reg_write;
  assign ex_mem_read  = q.mem_read;
  assign ex_mem_write = q.mem_write;
  assign ex_branch    = q.branch;
  assign ex_jump      = q.jump;
  assign ex_pc        = q.pc;
  assign ex_rd        = q.rd;
  assign ex_alu_ctrl  = q.alu_ctrl;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that feeds the execute-stage ALU in the five-stage RV32I core. It captures decoded fields from ID and selects ALU operand A and operand B from the register file, EX/MEM or MEM/WB results, PC, or the immediate. It detects load-use hazards and inserts bubbles for them, and supports downstream stall and control-flow flush. Its outputs connect directly to the ALU operand, control and branch-compare inputs and to the EX/MEM register.

## Interface
- No parameters. XLEN is fixed at 32 and register index width at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_rs1_data`, `id_rs2_data` in 32 each: register-file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_alu_ctrl` in 4: ALU operation code.
- `id_a_sel` in 2: operand A source. 00 = rs1, 01 = PC, 10 = zero, 11 is reserved and behaves as rs1.
- `id_b_imm` in 1: operand B source. 0 = rs2, 1 = imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump` in 1 each: control flags.
- `stall` in 1: downstream hold; freeze EX contents.
- `flush` in 1: squash the instruction entering EX (taken branch or jump).
- `exmem_rd` in 5, `exmem_reg_write` in 1, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_rd` in 5, `memwb_reg_write` in 1, `memwb_result` in 32: MEM/WB forwarding source.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jump` out 1 each.
- `ex_pc` out 32, `ex_rd` out 5, `ex_alu_ctrl` out 4.
- `ex_alu_a`, `ex_alu_b` out 32: ALU operands.
- `ex_store_data` out 32: forwarded rs2, used for stores.
- `ex_branch_target` out 32: `ex_pc + ex_imm`, modulo 2^32.
- `load_use_stall` out 1: tells IF/ID to hold for one cycle.

## Operation
- Registered fields are pc, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_ctrl, a_sel, b_imm, valid and the five control flags.
- Load-use hazard:
  - `load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (id_rs1 == ex_rd | id_rs2 == ex_rd)`.
  - The condition is evaluated combinationally every cycle.
  - It is forced to 0 while `stall` or `flush` is high.
- Update priority per clock edge: `rst` > `flush` > `stall` > `load_use_stall` > capture.
  - flush: load a bubble.
  - stall: hold all fields, except that rs1_data and rs2_data are overwritten with their current forwarded values. This ensures a result that drains out of MEM/WB during the stall is not lost.
  - load_use_stall: load a bubble.
  - capture: load all ID inputs.
- Bubble contents: valid=0, all five control flags=0, rd=0, alu_ctrl=0000 (ADD). Data fields are don't-care; the implementation loads zeros.
- Forwarding is combinational from registered rs1/rs2. It is applied per operand, separately for rs1 and rs2:
  - If `exmem_reg_write` is set, `exmem_rd` is nonzero and `exmem_rd` equals the operand index, select `exmem_result`.
  - Otherwise, if the same holds for memwb, select `memwb_result`.
  - Otherwise, select the registered data.
  - Forwarding never applies to register x0.
- `ex_alu_a` is chosen by a_sel from fwd_rs1, ex_pc, or 0.
- `ex_alu_b` is imm when b_imm is set, otherwise fwd_rs2.
- `ex_store_data` is always fwd_rs2.
- When branch compares are in use, the ID encoder sets b_imm=0 so the compare uses fwd_rs2.

## Timing
- ID to EX latency is 1 cycle.
- Forwarded operand outputs are valid in the same cycle that EX/MEM and MEM/WB inputs change, via a combinational path.
- Reset value of every output is 0: ex_valid=0, ex_alu_ctrl=0000, ex_alu_a=0, ex_alu_b=0, ex_branch_target=0, load_use_stall=0.
- A load-use hazard costs exactly one bubble. On the next cycle ex_mem_read=0, so load_use_stall drops and the held ID instruction is captured. Its operand is then forwarded from MEM/WB.
- If flush and stall are both high, flush wins.
- Asserting rst mid-operation clears all state immediately, without waiting for a clock edge.
- Sustained stall holds the stage indefinitely. Operand refresh continues every cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - The ALU opcode constants: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, BLT 1000, BGE 1001, BLTU 1010, BGEU 1011, BEQ 1100, BNE 1101, SRA 1110, SLTU 1111.
  - The `id_a_sel` encodings.
- Sub-module `fwd_unit` contains the pure combinational forwarding select for one operand. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 without waiting for a clock edge.
- EX/MEM forwarding: `add x5,x1,x2` then `sub x6,x5,x3` with exmem_rd=5, exmem_result=0x10 → ex_alu_a=0x10.
- Priority: exmem_rd=memwb_rd=5 with results 0xAA and 0xBB → ex_alu_a=0xAA. With rd=0, neither source is forwarded.
- Load-use: ex has `lw x7`; ID has `add x8,x7,x7` → load_use_stall=1 for one cycle and a bubble is captured (ex_valid=0, ex_reg_write=0). The next cycle captures the add, with x7 forwarded from memwb_result.
- Stall refresh: stall for 3 cycles while memwb presents rd=4, result=0x1234 for only one of those cycles. After the stall, the held rs1=x4 operand still reads 0x1234.
- Flush and stall together: flush=stall=1 → bubble loaded. Separately, ex_pc=0x100, imm=0xFFFFFFF0 → ex_branch_target=0xF0.
